// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic-cycle bus bundle between one master and wb_slave_mem.
//   cyc_i, stb_i, we_i        : cycle, strobe, write enable (master -> slave)
//   adr_i [ADDR_WIDTH]        : word address                (master -> slave)
//   dat_i [DATA_WIDTH]        : write data                  (master -> slave)
//   sel_i [DATA_WIDTH/8]      : write byte enables          (master -> slave)
//   dat_o [DATA_WIDTH]        : read data                   (slave -> master)
//   ack_o, err_o              : normal / error termination  (slave -> master)
// Signal names are taken from the slave's point of view.
interface wb_slave_mem_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) ();
    logic                    cyc_i;
    logic                    stb_i;
    logic                    we_i;
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    ack_o;
    logic                    err_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic-cycle slave backed by a small word-addressed register
// memory. Each accepted strobe is answered after WAIT_STATES idle cycles by a
// single-cycle ack_o (address < DEPTH) or err_o (address >= DEPTH).
// Ports:
//   clk_i    : sole clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   bus      : wb_slave_mem_if.slave (cyc/stb/we/adr/dat/sel in, dat/ack/err out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cyc_i & stb_i; request latched on acceptance
// WAIT  | counting down wait states; cyc_i low aborts the transfer
// RESP  | ack_o or err_o high for this one cycle; requests not sampled
module wb_slave_mem #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_slave_mem_if.slave     bus
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;

    logic                    lat_ld;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_adr;
    logic [DATA_WIDTH-1:0]   lat_dat;
    logic [SEL_W-1:0]        lat_sel;

    // With zero wait states the response edge is the acceptance edge, so the
    // live bus values must be used there; otherwise the latched copy is.
    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic [SEL_W-1:0]        cur_sel;
    logic                    in_range;

    logic                    enter_resp;
    logic                    mem_we;
    logic                    rd_en;
    logic                    ack_nx;
    logic                    err_nx;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign cur_we   = (state == IDLE) ? bus.we_i  : lat_we;
    assign cur_adr  = (state == IDLE) ? bus.adr_i : lat_adr;
    assign cur_dat  = (state == IDLE) ? bus.dat_i : lat_dat;
    assign cur_sel  = (state == IDLE) ? bus.sel_i : lat_sel;
    assign in_range = (32'(cur_adr) < 32'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        lat_ld     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cyc_i && bus.stb_i) begin
                    lat_ld = 1'b1;
                    cnt_nx = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.cyc_i) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        mem_we = enter_resp &  in_range &  cur_we;
        rd_en  = enter_resp &  in_range & ~cur_we;
        ack_nx = enter_resp &  in_range;
        err_nx = enter_resp & ~in_range;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_dat <= '0;
            lat_sel <= '0;
        end else if (lat_ld) begin
            lat_we  <= bus.we_i;
            lat_adr <= bus.adr_i;
            lat_dat <= bus.dat_i;
            lat_sel <= bus.sel_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (mem_we) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (cur_adr == ADDR_WIDTH'(w)) begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (cur_sel[b]) begin
                            mem[w][8*b +: 8] <= cur_dat[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;
            bus.dat_o <= '0;
        end else begin
            bus.ack_o <= ack_nx;
            bus.err_o <= err_nx;
            if (rd_en) begin
                bus.dat_o <= mem[cur_adr];
            end
        end
    end
endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Wishbone B4 classic-cycle slave backed by a small word-addressed register memory, with a configurable number of wait states before each acknowledge. It is the target that terminates bus cycles started by the team's Wishbone masters. Every accepted strobe gets exactly one single-cycle ACK or ERR, so it can close a master's wait-for-ACK loop. Out-of-range addresses are reported with ERR, and byte-lane writes honour SEL.

## Interface
- ADDR_WIDTH, 4: word-address width; DEPTH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32: data width; multiple of 8.
- DEPTH, 12: implemented words; addresses >= DEPTH are out of range.
- WAIT_STATES, 2: idle cycles between acceptance and response; >= 0.
- clk_i  in  1  sole clock; all state on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; transfer request when cyc_i & stb_i.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  word address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  DATA_WIDTH/8  write byte enables; bit n maps to dat bits [8n+7:8n].
- dat_o  out  DATA_WIDTH  read data, registered.
- ack_o  out  1  normal termination, registered.
- err_o  out  1  error termination, registered.

## Operation
- Reset (rst_n_i low, asynchronous) forces the following:
  - state IDLE, wait counter 0.
  - ack_o = 0, err_o = 0, dat_o = 0.
  - all DEPTH memory words cleared to 0.
  - Reset asserted mid-transfer discards the transfer: no response is given and nothing is written.
- States: IDLE, WAIT, RESP.
- IDLE: when cyc_i & stb_i are sampled high:
  - latch adr_i, we_i, dat_i and sel_i.
  - load the counter with WAIT_STATES.
  - go to WAIT, or directly to RESP if WAIT_STATES == 0.
- WAIT:
  - If cyc_i is sampled low, the transfer is aborted: go to IDLE with no response and no write.
  - Otherwise decrement the counter, and go to RESP on the edge where it reaches 0.
  - stb_i and all other inputs are ignored after acceptance; only the latched values are used.
- On the edge entering RESP, if the latched address is < DEPTH:
  - a write updates only the bytes whose sel bit is set.
  - a read loads the full word into dat_o; sel is ignored on reads.
- On the edge entering RESP, if the latched address is >= DEPTH:
  - set err_o instead of ack_o.
  - no memory write occurs and dat_o is unchanged.
- RESP: ack_o or err_o is high for exactly this one cycle. The next edge clears it and returns to IDLE unconditionally; requests are not sampled in RESP.
- dat_o holds its value until the next successful read; writes and errors do not change it.
- ack_o and err_o are never high together. A response is never produced without an accepted request.

## Timing
- Cycle 0 is the cycle in which cyc_i & stb_i are first high while in IDLE.
- Response (ack_o or err_o) is high in cycle WAIT_STATES+1 only.
- Write data is visible to a read accepted in any later cycle.
- Back-to-back transfers: if the master holds stb_i through the response cycle, the next request is accepted in cycle WAIT_STATES+2. Throughput is one transfer per WAIT_STATES+2 cycles (every other cycle when WAIT_STATES = 0).
- The master is expected to drop stb_i on the edge at which it samples ack_o. The RESP→IDLE cycle guarantees that the same strobe is never accepted twice.

## Test plan
All scenarios use DATA_WIDTH=32, DEPTH=12, WAIT_STATES=2.
- Reset: hold rst_n_i low mid-WAIT, then release -> ack_o=0, err_o=0, dat_o=0 immediately; a read of adr 3 returns 0 with ack_o high in cycle 3.
- Full-word write/read:
  - write 0xDEADBEEF to adr 5 with sel 4'hF -> ack_o high in cycle 3 only.
  - read adr 5 -> dat_o=0xDEADBEEF with ack_o in cycle 3.
- Byte lanes: write 0x11223344 to adr 5 with sel 4'b0101 -> a following read of adr 5 returns 0xDE22BE44.
- Out of range: write to adr 12 -> err_o high in cycle 3, ack_o stays 0; a read of adr 12 also gives err_o with dat_o unchanged.
- Abort: write 0x5A5A5A5A to adr 7, then drop cyc_i in cycle 1 -> no ack_o/err_o for 10 cycles; a read of adr 7 returns 0.
- Back-to-back: stb_i held high, reads of adr 5 then adr 0 -> ack_o high in cycles 3 and 7 only; with WAIT_STATES=0, ack_o high in cycles 1, 3 and 5.
